krnl_partialknn_local_sp_reader: RTL and testbench
==================================================

KRNL_PARTIALKNN_LOCAL_SP_READER -- requirements
Module: krnl_partialKnn_local_sp_reader

Interface
REQ-001 Parameter DataWidth, default 256: width in bits of one search-point word.
REQ-002 Parameter AddressWidth, default 11: local SP memory address width; AddressRange = 2**AddressWidth.
REQ-003 Parameter ReadLatency, default 1: cycles from ce0 high to valid q0; legal range 1..4.
REQ-004 clk  input  1: the single clock; all logic is rising-edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: single-cycle pulse that launches a read sweep; sampled only in IDLE.
REQ-007 base_addr  input  AddressWidth: first word address, captured on an accepted start.
REQ-008 num_words  input  AddressWidth+1: words to read (0..AddressRange), captured on an accepted start.
REQ-009 busy  output  1: high from the cycle after an accepted start until done.
REQ-010 done  output  1: one-cycle pulse when the last word has been accepted downstream.
REQ-011 address0  output  AddressWidth: read address to the local SP memory.
REQ-012 ce0  output  1: read enable to the local SP memory; we0 is not driven by this block.
REQ-013 q0  input  DataWidth: memory read data, valid ReadLatency cycles after ce0.
REQ-014 out_data  output  DataWidth: word toward the distance pipeline.
REQ-015 out_valid  output  1: out_data is valid.
REQ-016 out_ready  input  1: downstream accepts; transfer occurs when out_valid and out_ready are both high.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with num_words>0; IDLE->DONE on start with num_words==0.
REQ-018 RUN->DRAIN the cycle after the num_words-th read is issued; DRAIN->DONE when the final word transfers; DONE->IDLE unconditionally after one cycle, with done high during DONE.
REQ-019 start outside IDLE is ignored; base_addr and num_words changes after capture have no effect.
REQ-020 In RUN a read issues (ce0=1) when issued<num_words and outstanding+fifo_count<FifoDepth, FifoDepth=ReadLatency+2.
REQ-021 address0 = (base_addr + issued) mod AddressRange; wrap past AddressRange-1 to 0 is required behaviour.
REQ-022 A ReadLatency-deep valid shift register tracks issued reads; q0 is written into the output FIFO on the cycle its tag emerges.
REQ-023 The FIFO never overflows; the credit rule of REQ-020 guarantees this, including when out_ready is low for any duration.
REQ-024 Words emerge in address order, none dropped or duplicated; out_data holds steady while out_valid is high and out_ready low.
REQ-025 Latency: start at cycle 0 -> first ce0 at cycle 1 -> first out_valid at cycle 2+ReadLatency.
REQ-026 With out_ready held high, sustained throughput is one word per cycle.
REQ-027 FIFO simultaneous push and pop in the same cycle keeps the count unchanged and is legal when full or empty.
REQ-028 ce0 is low whenever address0 is not a requested read; address0 is don't-care while ce0 is low but is driven deterministic (last value).

Reset
REQ-029 Reset clears the FSM to IDLE and zeroes the counters, the shift register, and the FIFO pointers.
REQ-030 Outputs during and after reset: busy=0, done=0, ce0=0, address0=0, out_valid=0, out_data=0.
REQ-031 Reset mid-sweep abandons the sweep; in-flight q0 data is discarded and no done is produced.

Structure
REQ-032 The shared package holds FSM state encoding, the FifoDepth derivation function, and the default DataWidth/AddressWidth constants.
REQ-033 The output FIFO is one sub-module, krnl_partialKnn_local_sp_reader_fifo (register-based, parameterised depth and width, push/pop/count).
REQ-034 The memory itself is external; the block connects to the existing local SP 1R1W memory ports address0/ce0/q0.

Verification
REQ-035 base_addr=0, num_words=4, out_ready=1, words 0xA0..0xA3 -> out_data A0,A1,A2,A3 on consecutive cycles from cycle 2+ReadLatency; done on the cycle after A3 transfers.
REQ-036 base_addr=2046, num_words=4 -> address0 sequence 2046,2047,0,1; data returned in that order.
REQ-037 num_words=16, out_ready toggled 1-0-0-1 repeating -> all 16 words in order, no loss; ce0 stalls when outstanding+count=FifoDepth.
REQ-038 num_words=0 -> no ce0 pulse; done high exactly at cycle 2 after start; busy high only in cycle 1.
REQ-039 Reset asserted at word 5 of 10 -> all outputs 0 within the reset cycle; no done; a new start after release with num_words=3 completes correctly.
REQ-040 Repeat REQ-035 and REQ-037 with ReadLatency=1 and ReadLatency=3 -> identical data order; first out_valid at cycles 3 and 5.

Source files
------------

// File: rtl/krnl_partialknn_local_sp_reader_pkg.sv
// Shared definitions for the local search-point reader.
//   - rd_state_e  : sweep FSM encoding
//   - fifo_depth(): output FIFO depth needed to cover a given memory read latency
//   - default data/address widths for the local SP memory
package krnl_partialknn_local_sp_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_ADDR_WIDTH = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // One slot per read in the memory pipeline, one for the word held at the
    // output, and one spare so a full pipeline can stream at one word per cycle.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/krnl_partialknn_local_sp_reader_fifo.sv
// Register-based output FIFO for the SP reader.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset (pointers and count)
//   push_i, push_data_i : write a word
//   pop_i               : remove the head word (ignored when empty)
//   pop_data_o          : head word, zero when empty
//   count_o             : words currently held
// Push and pop in the same cycle leave the count unchanged, also when full.
module krnl_partialknn_local_sp_reader_fifo #(
    parameter int Depth = 3,
    parameter int Width = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             pop_data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/krnl_partialknn_local_sp_reader.sv
// Local search-point reader: sweeps num_words consecutive words of the local
// SP memory starting at base_addr and streams them, in address order, to the
// distance pipeline over a valid/ready handshake.
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   start_i                 : sweep launch pulse (accepted only when idle)
//   base_addr_i, num_words_i: sweep window, captured on an accepted start
//   busy_o, done_o          : sweep in progress / one-cycle completion pulse
//   address0_o, ce0_o, q0_i : local SP memory read port
//   out_data_o, out_valid_o, out_ready_i : output stream
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing reads, gated by FIFO credit
// ST_DRAIN | all reads issued, waiting for the last word to transfer
// ST_DONE  | one-cycle finish; done_o pulses here, or in the following
//          | cycle for a zero-length sweep (which still shows busy for
//          | one cycle so the caller sees the sweep happen)
module krnl_partialknn_local_sp_reader
    import krnl_partialknn_local_sp_reader_pkg::*;
#(
    parameter int DataWidth    = DEFAULT_DATA_WIDTH,
    parameter int AddressWidth = DEFAULT_ADDR_WIDTH,
    parameter int ReadLatency  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AddressWidth-1:0] base_addr_i,
    input  logic [AddressWidth:0]   num_words_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [AddressWidth-1:0] address0_o,
    output logic                    ce0_o,
    input  logic [DataWidth-1:0]    q0_i,
    output logic [DataWidth-1:0]    out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    localparam int FifoDepth = fifo_depth(ReadLatency);
    localparam int FifoCntW  = $clog2(FifoDepth + 1);
    localparam int CreditW   = FifoCntW + 1;
    localparam int NumW      = AddressWidth + 1;

    rd_state_e               state_q;
    logic                    busy_q, done_q;
    logic [AddressWidth-1:0] base_q, last_addr_q, addr_now;
    logic [NumW-1:0]         num_q, issued_q;
    logic [ReadLatency-1:0]  vld_q;
    logic [FifoCntW-1:0]     fifo_count;
    logic [CreditW-1:0]      outstanding, credit_used;
    logic [DataWidth-1:0]    fifo_data;
    logic                    issue, pop, out_valid, last_xfer;

    // Reads still travelling through the memory pipeline.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            outstanding = outstanding + CreditW'(vld_q[i]);
        end
    end

    // Every in-flight read already owns a FIFO slot, so back-pressure of any
    // length can never overflow the FIFO.
    assign credit_used = outstanding + CreditW'(fifo_count);
    assign issue       = (state_q == ST_RUN) && (issued_q < num_q)
                         && (credit_used < CreditW'(FifoDepth));
    assign addr_now    = base_q + issued_q[AddressWidth-1:0];

    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready_i;
    assign last_xfer   = (state_q == ST_DRAIN) && pop
                         && (fifo_count == FifoCntW'(1)) && (outstanding == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < ReadLatency; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            base_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            last_addr_q <= '0;
        end else begin
            if (issue) begin
                issued_q    <= issued_q + 1'b1;
                last_addr_q <= addr_now;
            end
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        base_q   <= base_addr_i;
                        num_q    <= num_words_i;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (num_words_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue && (issued_q + 1'b1 == num_q)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Still busy here only on the zero-length path.
                    state_q <= ST_IDLE;
                    done_q  <= busy_q;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    krnl_partialknn_local_sp_reader_fifo #(
        .Depth (FifoDepth),
        .Width (DataWidth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (vld_q[ReadLatency-1]),
        .push_data_i (q0_i),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .count_o     (fifo_count)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ce0_o       = issue;
    assign address0_o  = issue ? addr_now : last_addr_q;
    assign out_valid_o = out_valid;
    assign out_data_o  = fifo_data;

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
module tb_krnl_partialknn_local_sp_reader;

    localparam int DW = 256;
    localparam int AW = 11;
    localparam int AR = 2048;
    localparam int NV = 12;

    typedef struct {
        int base;
        int num;
        int mode;          // 0: ready high, 1: ready 1-0-0-1, 2: random ready
        bit poke;          // extra start pulse mid-sweep (must be ignored)
        int exp_first_l1;  // first out_valid cycle, -1 = never
        int exp_first_l3;
        int exp_done_l1;   // done cycle, -1 = not predicted
        int exp_done_l3;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          out_ready = 1'b1;

    logic busy_a, done_a, ce0_a, valid_a;
    logic busy_b, done_b, ce0_b, valid_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q0_a, q0_b, data_a, data_b;

    krnl_partialknn_local_sp_reader #(.DataWidth(DW), .AddressWidth(AW), .ReadLatency(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .num_words_i(num_words), .busy_o(busy_a), .done_o(done_a),
        .address0_o(addr_a), .ce0_o(ce0_a), .q0_i(q0_a),
        .out_data_o(data_a), .out_valid_o(valid_a), .out_ready_i(out_ready));

    krnl_partialknn_local_sp_reader #(.DataWidth(DW), .AddressWidth(AW), .ReadLatency(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .num_words_i(num_words), .busy_o(busy_b), .done_o(done_b),
        .address0_o(addr_b), .ce0_o(ce0_b), .q0_i(q0_b),
        .out_data_o(data_b), .out_valid_o(valid_b), .out_ready_i(out_ready));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word array plus a read pipeline of each DUT's latency.
    logic [DW-1:0] mem [AR];
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= ce0_a ? mem[addr_a] : '0;
        pipe_b[0] <= ce0_b ? mem[addr_b] : '0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign q0_a = pipe_a;
    assign q0_b = pipe_b[2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference bookkeeping per DUT (0: latency 1, 1: latency 3).
    int lat [2] = '{1, 3};
    int iss [2], xfer [2], first_ce [2], first_v [2], first_busy [2];
    int done_cyc [2], done_cnt [2], busy_cnt [2], max_inf [2];
    bit hold_v [2];
    logic [DW-1:0] hold_data [2];
    int cur_base = 0, cur_num = 0, t0 = 0;
    bit active = 1'b0;

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            iss[k] = 0; xfer[k] = 0; first_ce[k] = -1; first_v[k] = -1;
            first_busy[k] = -1; done_cyc[k] = -1; done_cnt[k] = 0;
            busy_cnt[k] = 0; max_inf[k] = 0; hold_v[k] = 1'b0;
        end
    endtask

    // The n-th read must address (base+n) mod AR, the n-th word out must be
    // mem[(base+n) mod AR], and reads may never exceed latency+2 in flight.
    task automatic mon(input int k, input logic busy, input logic done, input logic ce0,
                       input logic [AW-1:0] addr, input logic valid, input logic [DW-1:0] data);
        int rel;
        rel = cyc - t0;
        if (ce0) begin
            check("credit", (iss[k] - xfer[k]) < lat[k] + 2, 1);
            check("read_in_range", iss[k] < cur_num, 1);
            check("address0", addr, (cur_base + iss[k]) % AR);
            if (first_ce[k] < 0) first_ce[k] = rel;
            iss[k]++;
            if (iss[k] - xfer[k] > max_inf[k]) max_inf[k] = iss[k] - xfer[k];
        end
        if (hold_v[k]) begin
            check("hold_valid", valid, 1);
            check("hold_data", data, hold_data[k]);
        end
        if (valid && first_v[k] < 0) first_v[k] = rel;
        if (valid && out_ready) begin
            check("word_in_range", xfer[k] < cur_num, 1);
            check("out_data", data, mem[(cur_base + xfer[k]) % AR]);
            xfer[k]++;
        end
        hold_v[k] = valid && !out_ready;
        hold_data[k] = data;
        if (busy) begin
            busy_cnt[k]++;
            if (first_busy[k] < 0) first_busy[k] = rel;
        end
        if (done) begin
            done_cnt[k]++;
            done_cyc[k] = rel;
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            mon(0, busy_a, done_a, ce0_a, addr_a, valid_a, data_a);
            mon(1, busy_b, done_b, ce0_b, addr_b, valid_b, data_b);
        end
    end

    function automatic bit ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic vec_t mk(input int base, input int num, input int mode, input bit poke);
        vec_t v;
        v.base = base; v.num = num; v.mode = mode; v.poke = poke;
        v.exp_first_l1 = (num > 0) ? 2 + 1 : -1;
        v.exp_first_l3 = (num > 0) ? 2 + 3 : -1;
        v.exp_done_l1  = (mode != 0) ? -1 : (num > 0) ? 2 + 1 + num : 2;
        v.exp_done_l3  = (mode != 0) ? -1 : (num > 0) ? 2 + 3 + num : 2;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy_a"}, busy_a, 0);   check({tag, ".busy_b"}, busy_b, 0);
        check({tag, ".done_a"}, done_a, 0);   check({tag, ".done_b"}, done_b, 0);
        check({tag, ".ce0_a"}, ce0_a, 0);     check({tag, ".ce0_b"}, ce0_b, 0);
        check({tag, ".addr_a"}, addr_a, 0);   check({tag, ".addr_b"}, addr_b, 0);
        check({tag, ".valid_a"}, valid_a, 0); check({tag, ".valid_b"}, valid_b, 0);
        check({tag, ".data_a"}, data_a, 0);   check({tag, ".data_b"}, data_b, 0);
    endtask

    task automatic run_sweep(input vec_t v);
        int limit;
        bit fin;
        int exp_first, exp_done;
        @(posedge clk); #1;
        clear_stats();
        cur_base = v.base; cur_num = v.num; t0 = cyc;
        base_addr = 11'(v.base); num_words = 12'(v.num); start = 1'b1;
        out_ready = ready_for(v.mode, 0);
        limit = 8 * v.num + 40;
        fin = 1'b0;
        for (int c = 1; c < limit && !fin; c++) begin
            @(posedge clk); #1;
            start = v.poke && (c == 3);
            base_addr = 11'($urandom);
            num_words = 12'($urandom_range(0, AR));
            out_ready = ready_for(v.mode, c);
            if (done_cnt[0] > 0 && done_cnt[1] > 0 && c >= done_cyc[0] + 2 && c >= done_cyc[1] + 2)
                fin = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("sweep_finished", fin, 1);
        for (int k = 0; k < 2; k++) begin
            exp_first = (k == 0) ? v.exp_first_l1 : v.exp_first_l3;
            exp_done  = (k == 0) ? v.exp_done_l1 : v.exp_done_l3;
            check("done_pulses", done_cnt[k], 1);
            check("reads_issued", iss[k], v.num);
            check("words_out", xfer[k], v.num);
            check("busy_first", first_busy[k], 1);
            check("busy_len", busy_cnt[k], done_cyc[k] - 1);
            check("first_ce0", first_ce[k], (v.num > 0) ? 1 : -1);
            check("first_valid", first_v[k], exp_first);
            if (exp_done >= 0) check("done_cycle", done_cyc[k], exp_done);
            if (v.mode == 1 && v.num >= 8) check("credit_full", max_inf[k], lat[k] + 2);
        end
    endtask

    task automatic reset_mid_sweep();
        int waited;
        @(posedge clk); #1;
        clear_stats();
        cur_base = $urandom_range(0, AR - 1); cur_num = 10; t0 = cyc;
        base_addr = 11'(cur_base); num_words = 12'd10; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (xfer[0] < 5 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_word5", xfer[0] >= 5, 1);
        active = 1'b0;
        rst = 1'b1;
        #1;
        check_idle("mid_reset");
        repeat (2) begin
            @(negedge clk);
            check_idle("held_reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("after_reset");
        end
        active = 1'b1;
        run_sweep(mk($urandom_range(0, AR - 1), 3, 0, 1'b0));
    endtask

    vec_t vecs [NV];

    initial begin
        for (int i = 0; i < AR; i++) mem[i] = {8{$urandom}};
        mem[0] = 256'hA0; mem[1] = 256'hA1; mem[2] = 256'hA2; mem[3] = 256'hA3;

        vecs[0] = mk(0, 4, 0, 1'b1);
        vecs[1] = mk(2046, 4, 0, 1'b0);
        vecs[2] = mk(5, 16, 1, 1'b1);
        vecs[3] = mk(100, 0, 0, 1'b0);
        vecs[4] = mk(2047, 1, 0, 1'b0);
        vecs[5] = mk($urandom_range(0, AR - 1), AR, 0, 1'b1);
        for (int i = 6; i < NV; i++) begin
            int n;
            n = $urandom_range(1, 40);
            vecs[i] = mk($urandom_range(0, AR - 1), n, $urandom_range(0, 2), n >= 4);
        end

        repeat (2) @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        active = 1'b1;

        for (int i = 0; i < NV; i++) run_sweep(vecs[i]);
        reset_mid_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
